// File: rtl/display_clocks_pkg.sv
// display_clocks_pkg
// Shared definitions for the display clock supervisor: the FSM state
// encoding (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4) and small
// elaboration-time helpers used to size counters.
package display_clocks_pkg;

  localparam logic [2:0] RESET     = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;

  typedef enum logic [2:0] {
    S_RESET     = RESET,
    S_WAIT_LOCK = WAIT_LOCK,
    S_STABLE    = STABLE,
    S_RUN       = RUN,
    S_FAIL      = FAIL
  } state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_sync.sv
// display_sync
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronised output, STAGES clock cycles behind d
module display_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/display_clocks_supervisor.sv
// display_clocks_supervisor
// Drives the MMCM reset, watches its asynchronous LOCKED output and
// declares the display clocks usable once lock has been stable long
// enough. Retries on lock timeout, restarts on lock loss, and parks in
// a sticky fail state after too many consecutive timeouts.
// Ports:
//   i_clk          - free-running board clock
//   i_rst_n        - asynchronous active-low reset
//   i_locked       - MMCM LOCKED, asynchronous to i_clk
//   i_restart      - single-cycle request to re-run bring-up
//   o_mmcm_rst     - MMCM RST, active high
//   o_ready        - clocks locked and stable
//   o_fail         - retries exhausted, sticky until i_restart
//   o_lost_cnt     - saturating count of lock losses while running
//   o_timeout_cnt  - saturating count of lock timeouts
// Build option: define DISPLAY_CLOCKS_STATS_EN to implement the two
// statistics counters; otherwise both outputs are tied to zero.
module display_clocks_supervisor
  import display_clocks_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STAT_W        = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_locked,
  input  logic              i_restart,
  output logic              o_mmcm_rst,
  output logic              o_ready,
  output logic              o_fail,
  output logic [STAT_W-1:0] o_lost_cnt,
  output logic [STAT_W-1:0] o_timeout_cnt
);

  localparam int unsigned CNT_W = cnt_width(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam int unsigned RTY_W = cnt_width(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  logic             locked_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RTY_W-1:0] retries, retries_nxt;
  logic             timeout_ev;
  logic             lost_ev;

  display_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_locked),
    .q    (locked_s)
  );

  // One shared timer serves every state; it is cleared on each state
  // change so each state measures time from its own entry.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    retries_nxt = retries;
    timeout_ev  = 1'b0;
    lost_ev     = 1'b0;
    if (i_restart) begin
      // Restart wins over any simultaneous timeout or lock loss and
      // suppresses the matching statistic.
      state_nxt   = S_RESET;
      cnt_nxt     = '0;
      retries_nxt = '0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TMO_LAST) begin
            timeout_ev = 1'b1;
            cnt_nxt    = '0;
            if (retries == RTY_MAX) begin
              state_nxt = S_FAIL;
            end else begin
              retries_nxt = retries + RTY_W'(1);
              state_nxt   = S_RESET;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // A dropout here is treated as a glitch: wait for lock again
          // without pulsing the MMCM reset.
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt   = S_RUN;
            cnt_nxt     = '0;
            retries_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
            lost_ev   = 1'b1;
          end
        end
        S_FAIL: begin
          state_nxt = S_FAIL;
        end
        default: begin
          state_nxt = S_RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same
  // edge as the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_RESET;
      cnt        <= '0;
      retries    <= '0;
      o_mmcm_rst <= 1'b1;
      o_ready    <= 1'b0;
      o_fail     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retries    <= retries_nxt;
      o_mmcm_rst <= (state_nxt == S_RESET) || (state_nxt == S_FAIL);
      o_ready    <= (state_nxt == S_RUN);
      o_fail     <= (state_nxt == S_FAIL);
    end
  end

`ifdef DISPLAY_CLOCKS_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] lost_cnt;
  logic [STAT_W-1:0] timeout_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lost_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (lost_ev && (lost_cnt != STAT_MAX)) begin
        lost_cnt <= lost_cnt + STAT_W'(1);
      end
      if (timeout_ev && (timeout_cnt != STAT_MAX)) begin
        timeout_cnt <= timeout_cnt + STAT_W'(1);
      end
    end
  end

  assign o_lost_cnt    = lost_cnt;
  assign o_timeout_cnt = timeout_cnt;
`else
  logic unused_stat_events;
  assign unused_stat_events = lost_ev ^ timeout_ev;
  assign o_lost_cnt         = '0;
  assign o_timeout_cnt      = '0;
`endif

endmodule

// File: tb/tb_display_clocks_supervisor.sv
// tb_display_clocks_supervisor
// Bench for display_clocks_supervisor with small timing parameters.
// A driver applies directed and random lock/restart/reset sequences and,
// after each clock edge, pushes the reference model's expected outputs
// into a queue; a monitor on the falling edge pops and compares them.
// The reference model tracks bring-up phases and the time spent in each.
module tb_display_clocks_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 50;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int STAT_W        = 8;
  localparam int STAT_SAT      = (1 << STAT_W) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_locked;
  logic              i_restart;
  logic              o_mmcm_rst;
  logic              o_ready;
  logic              o_fail;
  logic [STAT_W-1:0] o_lost_cnt;
  logic [STAT_W-1:0] o_timeout_cnt;

  always #5 i_clk = ~i_clk;

  display_clocks_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .SYNC_STAGES  (SYNC_STAGES),
    .STAT_W       (STAT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_locked     (i_locked),
    .i_restart    (i_restart),
    .o_mmcm_rst   (o_mmcm_rst),
    .o_ready      (o_ready),
    .o_fail       (o_fail),
    .o_lost_cnt   (o_lost_cnt),
    .o_timeout_cnt(o_timeout_cnt)
  );

  typedef struct packed {
    logic              mmcm_rst;
    logic              ready;
    logic              fail;
    logic [STAT_W-1:0] lost;
    logic [STAT_W-1:0] tmo;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  always @(posedge i_clk) cycle++;

  // ---------------- reference model ----------------
  typedef enum int {PH_PULSE, PH_AWAIT, PH_SETTLE, PH_RUNNING, PH_GAVE_UP} phase_t;
  phase_t ph;
  int     elapsed;     // edges spent in the current phase
  int     tries;       // timeouts since last success/restart
  int     lost_n;
  int     tmo_n;
  bit     hist[$];     // recent i_locked samples, oldest first

  function automatic void enter(input phase_t p);
    ph      = p;
    elapsed = 0;
  endfunction

  function automatic void model_edge(input bit rst_n, input bit lk, input bit rs);
    bit ls;
    if (!rst_n) begin
      enter(PH_PULSE);
      tries  = 0;
      lost_n = 0;
      tmo_n  = 0;
      hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
      return;
    end
    ls = hist.pop_front();
    hist.push_back(lk);
    if (rs) begin
      enter(PH_PULSE);
      tries = 0;
      return;
    end
    case (ph)
      PH_PULSE: begin
        elapsed++;
        if (elapsed == RST_CYCLES) enter(PH_AWAIT);
      end
      PH_AWAIT: begin
        if (ls) enter(PH_SETTLE);
        else begin
          elapsed++;
          if (elapsed == LOCK_TIMEOUT) begin
            if (tmo_n < STAT_SAT) tmo_n++;
            if (tries == MAX_RETRIES) enter(PH_GAVE_UP);
            else begin
              tries++;
              enter(PH_PULSE);
            end
          end
        end
      end
      PH_SETTLE: begin
        if (!ls) enter(PH_AWAIT);
        else begin
          elapsed++;
          if (elapsed == STABLE_CYCLES) begin
            enter(PH_RUNNING);
            tries = 0;
          end
        end
      end
      PH_RUNNING: begin
        if (!ls) begin
          if (lost_n < STAT_SAT) lost_n++;
          enter(PH_PULSE);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.mmcm_rst = (ph == PH_PULSE) || (ph == PH_GAVE_UP);
    o.ready    = (ph == PH_RUNNING);
    o.fail     = (ph == PH_GAVE_UP);
`ifdef DISPLAY_CLOCKS_STATS_EN
    o.lost     = STAT_W'(lost_n);
    o.tmo      = STAT_W'(tmo_n);
`else
    o.lost     = '0;
    o.tmo      = '0;
`endif
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_mmcm_rst, o_ready, o_fail, o_lost_cnt, o_timeout_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got rst=%b rdy=%b fail=%b lost=%0d tmo=%0d expected rst=%b rdy=%b fail=%b lost=%0d tmo=%0d",
                 cycle, a.mmcm_rst, a.ready, a.fail, a.lost, a.tmo,
                 e.mmcm_rst, e.ready, e.fail, e.lost, e.tmo);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(input bit lk, input bit rs);
    i_locked  = lk;
    i_restart = rs;
    @(posedge i_clk);
    model_edge(i_rst_n, lk, rs);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Pull reset low between edges, check outputs respond at once, and
  // release it just after the following rising edge.
  task automatic pulse_reset();
    obs_t now;
    @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    now = {o_mmcm_rst, o_ready, o_fail, o_lost_cnt, o_timeout_cnt};
    check("async_reset_now", int'(now), int'(obs_t'({1'b1, 1'b0, 1'b0, {STAT_W{1'b0}}, {STAT_W{1'b0}}})));
    @(posedge i_clk);
    model_edge(1'b0, i_locked, i_restart);
    exp_q.push_back(model_out());
    #1 i_rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0);
      n++;
    end while (!o_ready && n < 60);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int guard;
    i_rst_n   = 1'b0;
    i_locked  = 1'b0;
    i_restart = 1'b0;
    model_edge(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    i_rst_n = 1'b1;

    // Clean bring-up
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (o_mmcm_rst && n < 20);
    check("rst_pulse_len", n, RST_CYCLES);
    repeat (9) step(1'b0, 1'b0);
    wait_ready(n);
    check("ready_latency", n, SYNC_STAGES + STABLE_CYCLES + 1);
    check("fail_after_bringup", int'(o_fail), 0);
    repeat (10) step(1'b1, 1'b0);

    // Lock loss in RUN
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (o_ready && n < 20);
    check("lock_loss_latency", n, SYNC_STAGES + 1);
    check("rst_after_loss", int'(o_mmcm_rst), 1);
`ifdef DISPLAY_CLOCKS_STATS_EN
    check("lost_cnt_after_loss", int'(o_lost_cnt), 1);
`else
    check("lost_cnt_after_loss", int'(o_lost_cnt), 0);
`endif
    repeat (10) step(1'b0, 1'b0);

    // Glitch in STABLE at stable count 5
    repeat (6) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    wait_ready(n);
    check("ready_after_glitch", n, SYNC_STAGES + STABLE_CYCLES + 1);
    repeat (5) step(1'b1, 1'b0);

    // Restart on the same edge the synchronised lock falls in RUN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("restart_enters_reset", int'(o_mmcm_rst), 1);
`ifdef DISPLAY_CLOCKS_STATS_EN
    check("lost_cnt_restart_prio", int'(o_lost_cnt), 1);
`else
    check("lost_cnt_restart_prio", int'(o_lost_cnt), 0);
`endif

    // Timeouts to FAIL
    n = 0;
    while (!o_fail && n < 400) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("timeouts_to_fail", n, (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT));
`ifdef DISPLAY_CLOCKS_STATS_EN
    check("timeout_cnt_at_fail", int'(o_timeout_cnt), MAX_RETRIES + 1);
`else
    check("timeout_cnt_at_fail", int'(o_timeout_cnt), 0);
`endif
    repeat (10) step(1'b0, 1'b0);
    check("fail_sticky", int'(o_fail), 1);

    // Restart out of FAIL
    step(1'b0, 1'b1);
    check("restart_clears_fail", int'(o_fail), 0);
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (o_mmcm_rst && n < 20);
    check("restart_pulse_len", n, RST_CYCLES);

    // Async reset mid-STABLE
    repeat (5) step(1'b1, 1'b0);
    pulse_reset();
    repeat (5) step(1'b1, 1'b0);

    // Random lock behaviour, restarts and resets
    for (int seg = 0; seg < 250; seg++) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(10, 70);
      for (int c = 0; c < len; c++) begin
        step(lk, ($urandom_range(0, 199) == 0));
      end
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    // Drive the lock-loss counter into saturation
    for (int it = 0; it < STAT_SAT + 15; it++) begin
      repeat (20) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end

    // Drive the timeout counter into saturation
    guard = 0;
    while (tmo_n < STAT_SAT + 3 && guard < 60000) begin
      step(1'b0, (ph == PH_GAVE_UP));
      guard++;
    end
    repeat (5) step(1'b0, 1'b0);

    // Let the monitor drain the queue
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge i_clk);
      guard++;
    end
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
